// File: rtl/aes_iter_enc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : aes_iter_enc
//  Purpose  : Iterative AES-128/AES-256 encryption engine. One round per
//             clock, round keys generated on the fly, valid/ready handshakes
//             and a user tag carried alongside each block.
//  Revision : 1.0  initial release
// ============================================================================
module aes_iter_enc #(
   parameter int KEY_BITS = 128,
   parameter int TAG_W    = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [TAG_W-1:0]    in_tag,
   input  logic [127:0]        plaintext,
   input  logic [KEY_BITS-1:0] key,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [127:0]        cypher,
   output logic [TAG_W-1:0]    out_tag,
   output logic                busy
);

   localparam int         NR   = (KEY_BITS == 256) ? 14 : 10;
   localparam logic [3:0] NR_L = 4'(NR);

   localparam logic [7:0] SBOX [0:255] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state;
   logic [127:0]        blk;        // AES state matrix, byte 0 in [127:120]
   logic [KEY_BITS-1:0] kw;         // key window: last one (128) or two (256) round keys
   logic [3:0]          round;
   logic [7:0]          rcon;
   logic [TAG_W-1:0]    tag_q;

   logic [127:0]        sb_blk;
   logic [127:0]        sr_blk;
   logic [127:0]        mc_blk;
   logic [127:0]        round_out;
   logic [31:0]         key_sub;
   logic [31:0]         ks_t;
   logic [127:0]        ks_base;
   logic [127:0]        rk_next;
   logic [127:0]        round_key;
   logic [KEY_BITS-1:0] kw_next;
   logic                rot_flag;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[x];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // Row r of column c is byte r+4c; row r rotates left by r columns.
   function automatic logic [127:0] shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
         end
      end
      return o;
   endfunction

   function automatic logic [127:0] mix_columns(input logic [127:0] s);
      logic [127:0] o;
      logic [7:0]   a0, a1, a2, a3;
      o = '0;
      for (int c = 0; c < 4; c++) begin
         a0 = s[127-32*c -: 8];
         a1 = s[119-32*c -: 8];
         a2 = s[111-32*c -: 8];
         a3 = s[103-32*c -: 8];
         o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   // Sixteen S-boxes for the data path.
   for (genvar i = 0; i < 16; i++) begin : g_sub_blk
      assign sb_blk[8*i +: 8] = sbox(blk[8*i +: 8]);
   end

   // Four S-boxes for the key schedule; they always see the newest key word.
   for (genvar i = 0; i < 4; i++) begin : g_sub_key
      assign key_sub[8*i +: 8] = sbox(kw[8*i +: 8]);
   end

   // SubWord(RotWord(x)) == RotWord(SubWord(x)), so rotation follows the S-boxes.
   assign ks_t    = rot_flag ? ({key_sub[23:0], key_sub[31:24]} ^ {rcon, 24'h0}) : key_sub;
   assign ks_base = kw[KEY_BITS-1 -: 128];
   assign rk_next[127:96] = ks_base[127:96] ^ ks_t;
   assign rk_next[95:64]  = ks_base[95:64]  ^ rk_next[127:96];
   assign rk_next[63:32]  = ks_base[63:32]  ^ rk_next[95:64];
   assign rk_next[31:0]   = ks_base[31:0]   ^ rk_next[63:32];

   if (KEY_BITS == 128) begin : g_k128
      // Window holds rk(r-1); the key for round r is derived this cycle.
      assign rot_flag  = 1'b1;
      assign round_key = rk_next;
      assign kw_next   = rk_next;
   end else if (KEY_BITS == 256) begin : g_k256
      // Window holds {rk(r-1), rk(r)}; this cycle derives rk(r+1), which is
      // an even-indexed key (RotWord + Rcon) exactly when r is odd.
      assign rot_flag  = round[0];
      assign round_key = kw[127:0];
      assign kw_next   = {kw[127:0], rk_next};
   end else begin : g_bad_key
      $error("aes_iter_enc: KEY_BITS must be 128 or 256");
   end

   assign sr_blk    = shift_rows(sb_blk);
   assign mc_blk    = mix_columns(sr_blk);
   assign round_out = ((round == NR_L) ? sr_blk : mc_blk) ^ round_key;

   // Control FSM plus all datapath registers and registered handshake outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         blk       <= '0;
         kw        <= '0;
         round     <= 4'd0;
         rcon      <= 8'h00;
         tag_q     <= '0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         cypher    <= '0;
         out_tag   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid && in_ready) begin
                  blk      <= plaintext ^ key[KEY_BITS-1 -: 128];
                  kw       <= key;
                  tag_q    <= in_tag;
                  round    <= 4'd1;
                  rcon     <= 8'h01;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               blk <= round_out;
               kw  <= kw_next;
               if (rot_flag) begin
                  rcon <= xtime(rcon);
               end
               if (round == NR_L) begin
                  cypher    <= round_out;
                  out_tag   <= tag_q;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  round <= round + 4'd1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  busy      <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_aes_iter_enc.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_aes_iter_enc
//  Purpose  : Self-checking bench for aes_iter_enc (AES-128 and AES-256
//             instances) with an independent reference cipher and scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module tb_aes_iter_enc;

   localparam int TAG_W = 8;

   logic             clk = 1'b0;
   logic             reset;

   // AES-128 instance
   logic             in_valid, in_ready, out_valid, out_ready, busy;
   logic [TAG_W-1:0] in_tag, out_tag;
   logic [127:0]     plaintext, cypher;
   logic [127:0]     key;

   // AES-256 instance
   logic             in_valid2, in_ready2, out_valid2, out_ready2, busy2;
   logic [TAG_W-1:0] in_tag2, out_tag2;
   logic [127:0]     plaintext2, cypher2;
   logic [255:0]     key2;

   int n_checks = 0;
   int n_errors = 0;

   logic [7:0] sbt [256];

   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [127:0]     ct;
   } exp_t;
   exp_t sb[$];

   always #5 clk = ~clk;

   aes_iter_enc #(.KEY_BITS(128), .TAG_W(TAG_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_tag(in_tag), .plaintext(plaintext), .key(key), .out_valid(out_valid),
      .out_ready(out_ready), .cypher(cypher), .out_tag(out_tag), .busy(busy)
   );

   aes_iter_enc #(.KEY_BITS(256), .TAG_W(TAG_W)) dut256 (
      .clk(clk), .reset(reset), .in_valid(in_valid2), .in_ready(in_ready2),
      .in_tag(in_tag2), .plaintext(plaintext2), .key(key2), .out_valid(out_valid2),
      .out_ready(out_ready2), .cypher(cypher2), .out_tag(out_tag2), .busy(busy2)
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic logic [7:0] gmul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      logic       hi;
      a = a_in; b = b_in; p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         hi = a[7];
         a  = {a[6:0], 1'b0};
         if (hi) a = a ^ 8'h1b;
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   // Multiplicative inverse followed by the affine transform.
   function automatic logic [7:0] sbox_calc(input logic [7:0] x);
      logic [7:0] inv, s;
      inv = 8'h01;
      for (int i = 0; i < 254; i++) inv = gmul(inv, x);
      if (x == 8'h00) inv = 8'h00;
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
              ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      return s;
   endfunction

   function automatic logic [31:0] subw(input logic [31:0] w);
      return {sbt[w[31:24]], sbt[w[23:16]], sbt[w[15:8]], sbt[w[7:0]]};
   endfunction

   // Key is left-justified in k; kb is 128 or 256.
   function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [255:0] k, input int kb);
      logic [31:0]  w [60];
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   rc;
      logic [31:0]  tmp;
      logic [127:0] o;
      int nk, nr;
      nk = kb / 32;
      nr = nk + 6;
      rc = 8'h01;
      for (int i = 0; i < 60; i++) w[i] = '0;
      for (int i = 0; i < nk; i++) w[i] = k[255-32*i -: 32];
      for (int i = nk; i < 4*(nr+1); i++) begin
         tmp = w[i-1];
         if (i % nk == 0) begin
            tmp = subw({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = gmul(rc, 8'h02);
         end else if (nk > 6 && i % nk == 4) begin
            tmp = subw(tmp);
         end
         w[i] = w[i-nk] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8];
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[c][31-8*r -: 8];
      for (int rnd = 1; rnd <= nr; rnd++) begin
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = sbt[s[r+4*((c+r)%4)]];
         for (int c = 0; c < 4; c++) begin
            if (rnd < nr) begin
               s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
               s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
            end else begin
               for (int r = 0; r < 4; r++) s[4*c+r] = t[4*c+r];
            end
            for (int r = 0; r < 4; r++) s[4*c+r] = s[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
         end
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a block to the AES-128 instance; returns #1 after the accept edge.
   task automatic accept(input logic [TAG_W-1:0] tg, input logic [127:0] pt, input logic [127:0] k);
      int n;
      in_valid  = 1'b1;
      in_tag    = tg;
      plaintext = pt;
      key       = k;
      n = 0;
      while (!in_ready && n < 50) begin
         tick();
         n++;
      end
      check("accept_ready", {127'd0, in_ready}, 128'd1);
      tick();
      in_valid  = 1'b0;
      plaintext = '0;
      key       = '0;
   endtask

   task automatic wait_valid(input int max, output int lat);
      lat = 0;
      while (!out_valid && lat < max) begin
         tick();
         lat++;
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, n, sent, got, gap, seen;
      logic pending;
      logic [127:0] pt, k, exp_ct, pt_b, k_b;
      logic [255:0] k256;
      exp_t e;

      for (int i = 0; i < 256; i++) sbt[i] = sbox_calc(8'(i));

      reset = 1'b1;
      in_valid = 0; in_tag = '0; plaintext = '0; key = '0; out_ready = 0;
      in_valid2 = 0; in_tag2 = '0; plaintext2 = '0; key2 = '0; out_ready2 = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      tick();

      // Reset state
      check("rst_in_ready",  {127'd0, in_ready},  128'd1);
      check("rst_out_valid", {127'd0, out_valid}, 128'd0);
      check("rst_busy",      {127'd0, busy},      128'd0);
      check("rst_cypher",    cypher,              128'd0);
      check("rst_out_tag",   {120'd0, out_tag},   128'd0);
      check("rst_in_ready2", {127'd0, in_ready2}, 128'd1);

      // FIPS-197 C.1
      out_ready = 1'b1;
      accept(8'h5a, C1_PT, C1_KEY);
      check("c1_busy",     {127'd0, busy},     128'd1);
      check("c1_in_ready", {127'd0, in_ready}, 128'd0);
      wait_valid(30, lat);
      check("c1_latency", 128'(lat), 128'd10);
      check("c1_cypher",  cypher, C1_CT);
      check("c1_tag",     {120'd0, out_tag}, 128'h5a);
      tick();
      check("c1_valid_1cyc", {127'd0, out_valid}, 128'd0);
      check("c1_in_ready_back", {127'd0, in_ready}, 128'd1);

      // FIPS-197 Appendix B
      accept(8'h3b, 128'h3243f6a8885a308d313198a2e0370734, 128'h2b7e151628aed2a6abf7158809cf4f3c);
      wait_valid(30, lat);
      check("b_cypher", cypher, 128'h3925841d02dc09fbdc118597196a0b32);
      tick();

      // FIPS-197 C.3 on the AES-256 instance, then one random 256-bit block
      for (int v = 0; v < 2; v++) begin
         out_ready2 = 1'b1;
         in_valid2  = 1'b1;
         in_tag2    = 8'(8'hc0 + v);
         plaintext2 = (v == 0) ? C1_PT : rnd128();
         key2       = (v == 0) ? 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f
                               : {rnd128(), rnd128()};
         exp_ct     = (v == 0) ? 128'h8ea2b7ca516745bfeafc49904b496089 : aes_ref(plaintext2, key2, 256);
         check("c3_in_ready", {127'd0, in_ready2}, 128'd1);
         tick();
         in_valid2 = 1'b0;
         lat = 0;
         while (!out_valid2 && lat < 40) begin
            tick();
            lat++;
         end
         check("aes256_latency", 128'(lat), 128'd14);
         check("aes256_cypher", cypher2, exp_ct);
         check("aes256_tag", {120'd0, out_tag2}, {120'd0, 8'(8'hc0 + v)});
         tick();
      end

      // Backpressure: result held, second block refused until released
      out_ready = 1'b0;
      pt = rnd128(); k = rnd128();
      exp_ct = aes_ref(pt, {k, 128'd0}, 128);
      accept(8'h11, pt, k);
      wait_valid(30, lat);
      pt_b = rnd128(); k_b = rnd128();
      in_valid = 1'b1; in_tag = 8'h22; plaintext = pt_b; key = k_b;
      for (int c = 0; c < 20; c++) begin
         check("bp_valid",    {127'd0, out_valid}, 128'd1);
         check("bp_cypher",   cypher, exp_ct);
         check("bp_tag",      {120'd0, out_tag}, 128'h11);
         check("bp_in_ready", {127'd0, in_ready}, 128'd0);
         tick();
      end
      out_ready = 1'b1;
      tick();
      check("bp_release_in_ready", {127'd0, in_ready}, 128'd1);
      tick();
      in_valid = 1'b0;
      wait_valid(30, lat);
      check("bp_next_latency", 128'(lat), 128'd10);
      check("bp_next_cypher", cypher, aes_ref(pt_b, {k_b, 128'd0}, 128));
      check("bp_next_tag", {120'd0, out_tag}, 128'h22);
      tick();

      // Reset in round 5
      accept(8'h77, C1_PT, C1_KEY);
      repeat (4) tick();
      reset = 1'b1;
      #1;
      check("mid_rst_out_valid", {127'd0, out_valid}, 128'd0);
      check("mid_rst_cypher",    cypher,              128'd0);
      check("mid_rst_in_ready",  {127'd0, in_ready},  128'd1);
      check("mid_rst_busy",      {127'd0, busy},      128'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      seen = 0;
      for (int c = 0; c < 15; c++) begin
         tick();
         if (out_valid) seen++;
      end
      check("mid_rst_no_output", 128'(seen), 128'd0);
      accept(8'h5a, C1_PT, C1_KEY);
      wait_valid(30, lat);
      check("post_rst_c1_cypher", cypher, C1_CT);
      tick();

      // Random traffic through the scoreboard
      sent = 0; got = 0; gap = 0; pending = 1'b0;
      n = 0;
      while (got < 50 && n < 5000) begin
         tick();
         n++;
         if (pending) begin
            in_valid = 1'b0;
            pending  = 1'b0;
            gap      = int'($urandom_range(0, 3));
         end
         if (!in_valid && sent < 50) begin
            if (gap > 0) begin
               gap--;
            end else begin
               in_valid  = 1'b1;
               in_tag    = 8'($urandom);
               plaintext = rnd128();
               key       = rnd128();
            end
         end
         if (in_valid && in_ready) begin
            e.tag = in_tag;
            e.ct  = aes_ref(plaintext, {key, 128'd0}, 128);
            sb.push_back(e);
            sent++;
            pending = 1'b1;
         end
         out_ready = 1'($urandom_range(0, 1));
         if (out_valid && out_ready) begin
            check("sb_nonempty", {127'd0, (sb.size() > 0)}, 128'd1);
            if (sb.size() > 0) begin
               e = sb.pop_front();
               check("rand_cypher", cypher, e.ct);
               check("rand_tag", {120'd0, out_tag}, {120'd0, e.tag});
            end
            got++;
         end
      end
      in_valid = 1'b0;
      check("rand_count", 128'(got), 128'd50);
      check("rand_sb_drained", 128'(sb.size()), 128'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/aes_iter_enc.md
# aes_iter_enc

Parametrised, iterative AES encryption engine: one AES round per clock, with the round-key schedule computed on the fly. It supports AES-128 and AES-256 through a parameter. It has valid/ready handshakes on input and output and passes a user tag through. It is the successor to the fully unrolled 10-stage AES-128 pipeline and trades throughput for area, so it fits behind the UART command path in the same design.

## Interface
- KEY_BITS, 128: key length, 128 or 256 only; any other value is an elaboration error.
- TAG_W, 8: width of the sideband tag carried with each block.
- NR (localparam), KEY_BITS==256 ? 14 : 10: number of rounds.
- clk  in  1  clock, all logic on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  plaintext, key and tag are valid.
- in_ready  out  1  engine can accept a block.
- in_tag  in  TAG_W  user tag, returned with the result.
- plaintext  in  128  block, byte 0 = bits [127:120] (FIPS-197 order).
- key  in  KEY_BITS  cipher key, same byte order.
- out_valid  out  1  cypher and out_tag are valid.
- out_ready  in  1  consumer accepts the result.
- cypher  out  128  ciphertext.
- out_tag  out  TAG_W  tag of the block in cypher.
- busy  out  1  high in RUN or DONE.

## Operation
- FSM states: IDLE, RUN, DONE. Reset puts the FSM in IDLE.
- Reset values: in_ready=1, out_valid=0, busy=0, cypher=0, out_tag=0. The internal state, key window and round counter are all 0.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: state <= plaintext ^ key[KEY_BITS-1 -: 128].
  - Load the key window with key: for 256-bit keys, both 128-bit halves.
  - Latch in_tag. Set round <= 1. Go to RUN.
- RUN:
  - in_ready=0. Each cycle, apply one round with the current round key.
  - Round r < NR: SubBytes, ShiftRows, MixColumns, AddRoundKey.
  - Round NR: omit MixColumns.
  - Advance the key schedule by one round key per cycle; round constant Rcon[i] per FIPS-197.
  - AES-256 schedule:
    - Even-indexed words use RotWord + SubWord + Rcon.
    - Odd-group words use SubWord only, with no Rcon.
    - Rcon advances once per two round keys.
  - At round == NR: cypher <= final state, out_tag <= latched tag, go to DONE.
  - Otherwise round <= round + 1.
- DONE:
  - out_valid=1. cypher and out_tag are held stable while out_ready=0.
  - On out_ready=1: out_valid <= 0, go to IDLE.
  - cypher keeps its last value after the handshake; it is not cleared.
- in_valid while busy: ignored; the inputs are not sampled.
- Key and plaintext inputs may change freely after the accept cycle.
- The round counter is 4 bits. It never wraps, because it saturates at NR via the state transition.
- S-box: combinational, 16 instances for state plus 4 for the key schedule. No block RAM, so every lookup completes in the same cycle.
- Reset asserted mid-operation:
  - Aborts immediately.
  - Outputs return to their reset values.
  - The in-flight block is discarded; no out_valid is produced for it.

## Timing
- Accept on edge E0 (in_valid & in_ready).
- Rounds 1..NR complete on edges E1..E_NR. out_valid is high after edge E_NR.
- Latency from accept to out_valid: NR cycles (10 for AES-128, 14 for AES-256).
- If out_ready is high when out_valid rises, in_ready rises one cycle later.
- Best-case throughput: one block per NR+2 cycles.
- in_ready is a registered function of state only; there is no combinational path from in_valid.
- out_valid is registered; there is no combinational path from out_ready to in_ready.

## Test plan
- AES-128, FIPS-197 C.1:
  - Stimulus: plaintext 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f, tag 0x5A, out_ready=1.
  - Required response: cypher 69c4e0d86a7b0430d8cdb78070b4c55a, out_tag 0x5A, out_valid exactly 10 cycles after accept, for 1 cycle.
- AES-128, FIPS-197 B:
  - Stimulus: plaintext 3243f6a8885a308d313198a2e0370734, key 2b7e151628aed2a6abf7158809cf4f3c.
  - Required response: cypher 3925841d02dc09fbdc118597196a0b32.
- AES-256, FIPS-197 C.3 (KEY_BITS=256):
  - Stimulus: plaintext 00112233445566778899aabbccddeeff, key 000102…1e1f.
  - Required response: cypher 8ea2b7ca516745bfeafc49904b496089, latency 14 cycles.
- Backpressure:
  - Stimulus: hold out_ready=0 for 20 cycles after out_valid.
  - Required response: cypher, out_tag and out_valid stay stable; in_ready stays 0; a new in_valid with a different block is not accepted.
  - Then release out_ready: in_ready rises and the next block produces the correct result.
- Reset mid-operation:
  - Stimulus: assert reset at round 5 of a block.
  - Required response: out_valid=0, cypher=0, in_ready=1 immediately.
  - A following C.1 vector still produces 69c4e0d86a7b0430d8cdb78070b4c55a.
- Back-to-back:
  - Stimulus: 50 random blocks with random in_valid/out_ready gaps.
  - Required response: results match a reference model in order, with tags matching.
